// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size/sign encodings,
// controller states and the byte-enable / legality helpers.
package lsu_pkg;

    // funct3 encodings; stores reuse the B/H/W codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Byte enables from access size (funct3[1:0]) and the low address bits.
    // Half accesses only look at addr[1], so a misaligned half wraps down.
    function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Loads accept B/H/W/BU/HU, stores only B/H/W.
    function automatic logic lsu_f3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        if (!we) begin
            ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

    // Half needs addr[0] clear, word needs addr[1:0] clear.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: selects the addressed byte/half from a memory word
// and sign- or zero-extends it according to funct3. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign byte_shift = rdata >> {addr, 3'b000};
    assign half_shift = rdata >> {addr[1], 4'b0000};

    // Extend the selected field; LW (and anything else) passes the word through
    always_comb begin
        case (funct3)
            F3_B:    data_out = {{24{byte_shift[7]}}, byte_shift[7:0]};
            F3_BU:   data_out = {24'h0, byte_shift[7:0]};
            F3_H:    data_out = {{16{half_shift[15]}}, half_shift[15:0]};
            F3_HU:   data_out = {16'h0, half_shift[15:0]};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller. One transaction at a time:
// IDLE -> REQ -> (WAIT) -> RESP, with illegal accesses going IDLE -> RESP.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned half/word
// accesses into error responses instead of silently aligning them down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_req_ready,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_mem_valid,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    lsu_state_t        state_reg;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        mem_be_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    logic              req_bad;
    logic [DATA_W-1:0] wdata_repl;
    logic [DATA_W-1:0] load_fmt;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_bad = !lsu_f3_legal(i_req_we, i_req_funct3)
                   || lsu_misaligned(i_req_funct3, i_req_addr[1:0]);
`else
    assign req_bad = !lsu_f3_legal(i_req_we, i_req_funct3);
`endif

    // Replicate store data across lanes so the memory only needs the enables
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_repl[8*gi +: 8] =
                (i_req_funct3[1:0] == 2'b00) ? i_req_wdata[7:0] :
                (i_req_funct3[1:0] == 2'b01) ? i_req_wdata[8*(gi%2) +: 8] :
                                               i_req_wdata[8*gi +: 8];
        end
    endgenerate

    lsu_load_align u_align (
        .rdata    (i_mem_rdata),
        .addr     (addr_reg[1:0]),
        .funct3   (funct3_reg),
        .data_out (load_fmt)
    );

    // Transaction FSM; all memory-side and response outputs come from these registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_reg      <= '0;
            mem_be_reg    <= 4'b0000;
            mem_wdata_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_req_valid) begin
                        we_reg        <= i_req_we;
                        funct3_reg    <= i_req_funct3;
                        addr_reg      <= i_req_addr;
                        rsp_rdata_reg <= '0;
                        if (req_bad) begin
                            // No memory access; answer with an error next cycle
                            rsp_err_reg <= 1'b1;
                            state_reg   <= RESP;
                        end else begin
                            mem_be_reg    <= lsu_be(i_req_funct3, i_req_addr[1:0]);
                            mem_wdata_reg <= wdata_repl;
                            state_reg     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_ready) begin
                        state_reg <= we_reg ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        rsp_rdata_reg <= load_fmt;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    rsp_rdata_reg <= '0;
                    rsp_err_reg   <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (state_reg == IDLE);
    assign o_mem_valid = (state_reg == REQ);
    assign o_rsp_valid = (state_reg == RESP);
    assign o_rsp_rdata = rsp_rdata_reg;
    assign o_rsp_err   = rsp_err_reg;
    assign o_mem_we    = we_reg;
    assign o_mem_be    = mem_be_reg;
    assign o_mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign o_mem_wdata = mem_wdata_reg;

endmodule
